// File: rtl/alarm_ringer.sv
// Alarm ringer: compares the running time with the stored alarm time and drives
// the ring/buzzer/snooze outputs, including snooze limits, stop and ring timeout.
module alarm_ringer #(
  parameter int unsigned RING_SECS      = 60,
  parameter int unsigned SNOOZE_SECS    = 300,
  parameter int unsigned MAX_SNOOZE     = 3,
  parameter logic [2:0]  SET_ALARM_MODE = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       sec_tick,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic [4:0] a_hours,
  input  logic [5:0] a_minutes,
  input  logic [5:0] a_seconds,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozing,
  output logic [2:0] snooze_count
);

  localparam int unsigned CW = 9;
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_SECS - 1);
  localparam logic [2:0]    SNZ_MAX   = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] ring_cnt, ring_cnt_d;
  logic [CW-1:0] snz_cnt, snz_cnt_d;
  logic          buzzer_d;
  logic [2:0]    snooze_count_d;
  logic          match_q, snooze_q, stop_q;
  logic          match, edit_mode, trig, snz_e, stp_e;

  assign match     = (cur_hours == a_hours) && (cur_minutes == a_minutes) &&
                     (cur_seconds == a_seconds);
  assign edit_mode = (mode == SET_ALARM_MODE);
  // Fires only on the first clk of a matching second
  assign trig      = match & ~match_q & ~edit_mode;
  assign snz_e     = snooze_btn & ~snooze_q;
  assign stp_e     = stop_btn & ~stop_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      snooze_count <= '0;
      match_q      <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state        <= state_d;
      ring_cnt     <= ring_cnt_d;
      snz_cnt      <= snz_cnt_d;
      buzzer       <= buzzer_d;
      ringing      <= (state_d == RINGING);
      snoozing     <= (state_d == SNOOZE);
      snooze_count <= snooze_count_d;
      match_q      <= match;
      snooze_q     <= snooze_btn;
      stop_q       <= stop_btn;
    end
  end

  // Next-state logic; disarming overrides everything
  always_comb begin
    state_d = state;
    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    state_d = ARMED;
        ARMED:   if (trig) state_d = RINGING;
        RINGING: begin
          if (stp_e || edit_mode)                  state_d = ARMED;
          else if (snz_e && snooze_count < SNZ_MAX) state_d = SNOOZE;
          else if (sec_tick && ring_cnt == RING_LAST) state_d = ARMED;
        end
        SNOOZE: begin
          if (stp_e || edit_mode)                  state_d = ARMED;
          else if (sec_tick && snz_cnt == SNZ_LAST) state_d = RINGING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter/buzzer updates keyed on the transition being taken
  always_comb begin
    ring_cnt_d     = ring_cnt;
    snz_cnt_d      = snz_cnt;
    buzzer_d       = buzzer;
    snooze_count_d = snooze_count;
    case (state_d)
      RINGING: begin
        if (state != RINGING) begin
          ring_cnt_d = '0;
          buzzer_d   = 1'b1;
        end else if (sec_tick) begin
          ring_cnt_d = ring_cnt + CW'(1);
          buzzer_d   = ~buzzer;
        end
      end
      SNOOZE: begin
        buzzer_d = 1'b0;
        if (state != SNOOZE) begin
          snz_cnt_d      = '0;
          snooze_count_d = snooze_count + 3'd1;
        end else if (sec_tick) begin
          snz_cnt_d = snz_cnt + CW'(1);
        end
      end
      default: begin
        ring_cnt_d     = '0;
        snz_cnt_d      = '0;
        buzzer_d       = 1'b0;
        snooze_count_d = '0;
      end
    endcase
  end

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Alarm-side consumer of the stored alarm time: reads the alarm hours/minutes/seconds registers and compares them with the running clock time.
- On a match, drives the ring/buzzer outputs, with snooze, stop and ring-timeout handling.
- Sits between the alarm-setting logic, the timekeeping counter and the buzzer/LED output.
- Suppresses triggering while the alarm is being edited (mode 3'b110).

Parameters:
- RING_SECS, 60: seconds a ring lasts before auto-stop; 1..511.
- SNOOZE_SECS, 300: snooze length in seconds; 1..511.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; 0..7.
- SET_ALARM_MODE, 3'b110: mode code during which the alarm is being edited.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- mode, input, 3: current top-level mode.
- sec_tick, input, 1: one-cycle pulse, once per second.
- cur_hours, input, 5: current time hours.
- cur_minutes, input, 6: current time minutes.
- cur_seconds, input, 6: current time seconds.
- a_hours, input, 5: alarm hours.
- a_minutes, input, 6: alarm minutes.
- a_seconds, input, 6: alarm seconds.
- alarm_en, input, 1: alarm armed switch (level).
- snooze_btn, input, 1: debounced snooze button (level).
- stop_btn, input, 1: debounced stop button (level).
- ringing, output, 1: high while in RINGING.
- buzzer, output, 1: buzzer drive, toggles each second while ringing.
- snoozing, output, 1: high while in SNOOZE.
- snooze_count, output, 3: snoozes used in the current alarm event.

Behaviour:
- Reset (rst=1, async): state=IDLE; ringing=0, buzzer=0, snoozing=0, snooze_count=0; ring_cnt=0, snz_cnt=0 (9 bits each); match_q=0; btn edge registers=0.
- All outputs are registered. A state change is visible on the outputs one clk after the causing input is sampled.
- match: combinational, true when all three time fields equal the three alarm fields. match_q is match registered each clk.
- trig: match & ~match_q & (mode != SET_ALARM_MODE). It fires once per match second, with no retrigger while time stays equal.
- Button edges: snz_e = snooze_btn & ~snooze_q; stp_e = stop_btn & ~stop_q.
- A button held high when reset releases yields one edge on the first clk.
- Global rule, highest priority: alarm_en=0 -> IDLE next clk from any state; clears counters, snooze_count and all outputs.
- IDLE: alarm_en=1 -> ARMED.
- ARMED:
  - trig -> RINGING; ring_cnt=0; buzzer=1.
  - snooze_count cleared on every entry to ARMED.
- RINGING, in priority order:
  - stp_e -> ARMED.
  - mode==SET_ALARM_MODE -> ARMED (cancel).
  - snz_e and snooze_count<MAX_SNOOZE -> SNOOZE; snz_cnt=0; snooze_count+1; buzzer=0.
  - snz_e with snooze_count==MAX_SNOOZE is ignored.
  - sec_tick: if ring_cnt==RING_SECS-1 -> ARMED (timeout); else ring_cnt+1 and buzzer toggles.
- SNOOZE, in priority order:
  - stp_e or mode==SET_ALARM_MODE -> ARMED.
  - sec_tick: if snz_cnt==SNOOZE_SECS-1 -> RINGING, ring_cnt=0, buzzer=1; else snz_cnt+1.
  - A trig during SNOOZE is ignored.
- Simultaneous stp_e and snz_e: stop wins.
- A stp_e in the same clk as the timeout tick yields ARMED (same result either way).
- On leaving RINGING/SNOOZE for any reason: buzzer=0, ringing=0, snoozing=0.
- Reset asserted mid-ring: immediate return to reset values. The alarm does not resume after release unless a new match edge occurs.
- Counters never wrap: they are bounded by their parameter compare.

Test Plan:
- Reset, alarm_en=1, alarm 07:30:00; time steps to 07:30:00 -> ringing=1 one clk later, buzzer=1. Time held for 10 clks -> no retrigger.
- Ringing, 60 sec_ticks with no buttons -> buzzer toggles each tick; ringing=0 after the 60th tick; state ARMED.
- Ringing, snooze_btn pulse -> snoozing=1, snooze_count=1. 300 ticks later -> ringing=1. Repeat to snooze_count=3; 4th snooze press ignored, ringing stays 1.
- Ringing, snooze_btn and stop_btn rise in the same clk -> ARMED, snoozing=0, snooze_count=0.
- mode=3'b110 while time reaches the alarm value -> no ring. mode=3'b110 entered while SNOOZE -> ARMED.
- Ringing, rst pulsed asynchronously mid-cycle -> all outputs 0 immediately. alarm_en=0 during SNOOZE -> IDLE, no later ring.
